// File: rtl/seq_div.sv
// ============================================================================
// Module  : seq_div
// Purpose : Sequential restoring divider for sign-magnitude fixed point.
//           The quotient saturates on overflow and on divide-by-zero.
// Revision: 1.0
// ============================================================================
`default_nettype none

module seq_div #(
  parameter int N = 16,
  parameter int F = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic [N-1:0] c_o,
  output logic         done_o,
  output logic         busy_o,
  output logic         ovf_o,
  output logic         dbz_o
);

  localparam int ITER = N - 1 + F;
  localparam int CW   = $clog2(ITER);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            sgn_q, sgn_d;
  logic [N-2:0]    d_q, d_d;
  logic [ITER-1:0] dsr_q, dsr_d;
  logic [N-1:0]    rem_q, rem_d;
  logic [ITER-1:0] quo_q, quo_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N-1:0]    c_q, c_d;
  logic            ovf_q, ovf_d;
  logic            dbz_q, dbz_d;

  logic [N-1:0]    w_rsh;
  logic [N-1:0]    w_dext;
  logic [N-1:0]    w_rsub;
  logic            w_ge;
  logic [ITER-1:0] w_qnext;
  logic            w_dbz;
  logic            w_ovf;
  logic [N-2:0]    w_mag;
  logic            w_sign;

  // Remainder stays below the divisor, so its top bit is always zero and drops out.
  assign w_rsh   = N'({rem_q, dsr_q[ITER-1]});
  assign w_dext  = {1'b0, d_q};
  assign w_rsub  = w_rsh - w_dext;
  assign w_ge    = (w_rsh >= w_dext);
  assign w_qnext = ITER'({quo_q, w_ge});

  assign w_dbz  = (d_q == '0);
  assign w_ovf  = !w_dbz && (|w_qnext[ITER-1:N-1]);
  assign w_mag  = (w_dbz || w_ovf) ? '1 : w_qnext[N-2:0];
  assign w_sign = sgn_q & (|w_mag);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      sgn_q   <= 1'b0;
      d_q     <= '0;
      dsr_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      c_q     <= '0;
      ovf_q   <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sgn_q   <= sgn_d;
      d_q     <= d_d;
      dsr_q   <= dsr_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      ovf_q   <= ovf_d;
      dbz_q   <= dbz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sgn_d   = sgn_q;
    d_d     = d_q;
    dsr_d   = dsr_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    ovf_d   = ovf_q;
    dbz_d   = dbz_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_d = S_RUN;
          sgn_d   = a_i[N-1] ^ b_i[N-1];
          d_d     = b_i[N-2:0];
          dsr_d   = {a_i[N-2:0], {F{1'b0}}};
          rem_d   = '0;
          quo_d   = '0;
          cnt_d   = '0;
        end else if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        rem_d = w_ge ? w_rsub : w_rsh;
        quo_d = w_qnext;
        dsr_d = {dsr_q[ITER-2:0], 1'b0};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(ITER - 1)) begin
          state_d = S_DONE;
          c_d     = {w_sign, w_mag};
          ovf_d   = w_ovf;
          dbz_d   = w_dbz;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign c_o    = c_q;
  assign ovf_o  = ovf_q;
  assign dbz_o  = dbz_q;
  assign done_o = (state_q == S_DONE);
  assign busy_o = (state_q == S_RUN);

endmodule

`default_nettype wire

// File: tb/tb_seq_div.sv
// ============================================================================
// Module  : tb_seq_div
// Purpose : Directed self-checking bench for seq_div against an arithmetic model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_seq_div;

  localparam int N    = 16;
  localparam int F    = 8;
  localparam int ITER = N - 1 + F;

  logic         clk   = 1'b0;
  logic         rst   = 1'b0;
  logic         start = 1'b0;
  logic [N-1:0] a     = '0;
  logic [N-1:0] b     = '0;
  logic [N-1:0] c;
  logic         done, busy, ovf, dbz;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_div #(.N(N), .F(F)) dut (
    .clk    (clk),
    .rst    (rst),
    .start_i(start),
    .a_i    (a),
    .b_i    (b),
    .c_o    (c),
    .done_o (done),
    .busy_o (busy),
    .ovf_o  (ovf),
    .dbz_o  (dbz)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Result straight from the arithmetic definition: {ovf, dbz, c}
  function automatic logic [N+1:0] ref_div(input logic [N-1:0] x, input logic [N-1:0] y);
    longint       ma, mb, qf;
    logic         s, o, z;
    logic [N-2:0] mag;
    ma  = longint'(x[N-2:0]);
    mb  = longint'(y[N-2:0]);
    s   = x[N-1] ^ y[N-1];
    o   = 1'b0;
    z   = 1'b0;
    if (mb == 0) begin
      z   = 1'b1;
      mag = '1;
    end else begin
      qf = (ma << F) / mb;
      if (qf > (longint'(1) << (N - 1)) - 1) begin
        o   = 1'b1;
        mag = '1;
      end else begin
        mag = qf[N-2:0];
      end
    end
    if (mag == '0) s = 1'b0;
    return {o, z, s, mag};
  endfunction

  logic         m_busy = 1'b0, m_done = 1'b0, m_ovf = 1'b0, m_dbz = 1'b0;
  logic [N-1:0] m_c = '0, m_a = '0, m_b = '0;
  int           m_cnt = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_ovf  <= 1'b0;
      m_dbz  <= 1'b0;
      m_c    <= '0;
      m_cnt  <= 0;
    end else if (m_busy) begin
      m_cnt  <= m_cnt + 1;
      m_done <= 1'b0;
      if (m_cnt == ITER - 1) begin
        {m_ovf, m_dbz, m_c} <= ref_div(m_a, m_b);
        m_done <= 1'b1;
        m_busy <= 1'b0;
      end
    end else begin
      m_done <= 1'b0;
      if (start) begin
        m_busy <= 1'b1;
        m_cnt  <= 0;
        m_a    <= a;
        m_b    <= b;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst)
      chk("cycle{c,ovf,dbz,busy,done}", {12'd0, c, ovf, dbz, busy, done},
          {12'd0, m_c, m_ovf, m_dbz, m_busy, m_done});
  end

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!done && n < 40);
  endtask

  task automatic run_op(input string name, input logic [N-1:0] x, input logic [N-1:0] y,
                        input logic [N-1:0] ec, input logic eo, input logic ez);
    int n;
    a     = x;
    b     = y;
    start = 1'b1;
    @(posedge clk);
    #2 start = 1'b0;
    wait_done(n);
    chk({name, "_latency"}, n + 0, ITER);
    chk({name, "_c"}, {16'd0, c}, {16'd0, ec});
    chk({name, "_ovf"}, {31'd0, ovf}, {31'd0, eo});
    chk({name, "_dbz"}, {31'd0, dbz}, {31'd0, ez});
    chk({name, "_model_c"}, {16'd0, m_c}, {16'd0, ec});
  endtask

  logic [N-1:0] bb_a [4] = '{16'h0300, 16'h8100, 16'h0C00, 16'h0001};
  logic [N-1:0] bb_b [4] = '{16'h0200, 16'h0400, 16'h8300, 16'h0100};
  logic [N-1:0] bb_c [4] = '{16'h0180, 16'h8040, 16'h8400, 16'h0001};

  initial begin
    int n;
    #1 rst = 1'b1;
    #1;
    chk("reset_outputs", {12'd0, c, ovf, dbz, busy, done}, 32'd0);
    @(posedge clk);
    #2 rst = 1'b0;

    run_op("basic_pos", 16'h0300, 16'h0200, 16'h0180, 1'b0, 1'b0);
    run_op("basic_neg", 16'h8100, 16'h0400, 16'h8040, 1'b0, 1'b0);
    run_op("trunc",     16'h0100, 16'h0300, 16'h0055, 1'b0, 1'b0);
    run_op("neg_zero",  16'h8000, 16'h0100, 16'h0000, 1'b0, 1'b0);
    run_op("div_zero",  16'h8100, 16'h0000, 16'hFFFF, 1'b0, 1'b1);
    run_op("overflow",  16'h7F00, 16'h0001, 16'h7FFF, 1'b1, 1'b0);
    run_op("after_ovf", 16'h0300, 16'h0200, 16'h0180, 1'b0, 1'b0);

    // start held high; fresh operands presented during each DONE cycle
    a = bb_a[0];
    b = bb_b[0];
    start = 1'b1;
    @(posedge clk);
    #2;
    for (int k = 0; k < 4; k++) begin
      wait_done(n);
      chk($sformatf("b2b%0d_interval", k), n + 0, (k == 0) ? ITER : ITER + 1);
      chk($sformatf("b2b%0d_c", k), {16'd0, c}, {16'd0, bb_c[k]});
      if (k < 3) begin
        a = bb_a[k+1];
        b = bb_b[k+1];
      end else begin
        start = 1'b0;
      end
    end
    @(posedge clk);
    #2;

    // start pulses and operand changes during RUN must be ignored
    a = 16'h0300;
    b = 16'h0200;
    start = 1'b1;
    @(posedge clk);
    #2 start = 1'b0;
    a = 16'h0100;
    b = 16'h0300;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #2 start = 1'b1;
      @(posedge clk);
      #2 start = 1'b0;
    end
    wait_done(n);
    chk("ignore_latency", n + 10, ITER);
    chk("ignore_c", {16'd0, c}, 32'h0180);

    // reset while at iteration 10
    a = 16'h8100;
    b = 16'h0400;
    start = 1'b1;
    @(posedge clk);
    #2 start = 1'b0;
    repeat (10) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("midrun_reset_outputs", {12'd0, c, ovf, dbz, busy, done}, 32'd0);
    @(posedge clk);
    #2 rst = 1'b0;
    repeat (30) @(posedge clk);
    #2;
    run_op("post_reset", 16'h0100, 16'h0300, 16'h0055, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete by %0t", $time);
    $fatal(1);
  end

endmodule

`default_nettype wire
